// File: rtl/rio_pkg.sv
// Shared SRIO HELLO-format constants, header layout and initiator FSM states.
package rio_pkg;

    localparam logic [3:0] FTYPE_NWRITE   = 4'd5;
    localparam logic [3:0] FTYPE_DOORBELL = 4'd10;
    localparam logic [3:0] FTYPE_RESPONSE = 4'd13;

    localparam logic [3:0] TTYPE_DOORBELL = 4'd0;
    localparam logic [3:0] TTYPE_NWRITE   = 4'd4;
    localparam logic [3:0] TTYPE_NWRITE_R = 4'd5;

    localparam logic [1:0] HELLO_PRIO = 2'b01;
    localparam logic [3:0] RESP_DONE  = 4'd0;

    typedef struct packed {
        logic [7:0]  tid;
        logic [3:0]  ftype;
        logic [3:0]  ttype;
        logic        rsvd_hi;
        logic [1:0]  prio;
        logic        crf;
        logic [7:0]  size;
        logic [1:0]  rsvd_lo;
        logic [33:0] addr;
    } hello_hdr_t;

    typedef enum logic [2:0] {
        StLinkWait,
        StDbIdle,
        StDbSend,
        StDbWait,
        StNwrIdle,
        StNwrHdr,
        StNwrData,
        StNwrResp
    } rio_state_e;

endpackage

// File: rtl/rio_hello_hdr.sv
// Combinational HELLO request header builder: fixed priority 01, CRF 0, reserved bits 0.
module rio_hello_hdr
    import rio_pkg::*;
(
    input  logic [7:0]  tid,
    input  logic [3:0]  ftype,
    input  logic [3:0]  ttype,
    input  logic [7:0]  size,
    input  logic [33:0] addr,
    output logic [63:0] hdr
);

    hello_hdr_t h;

    always_comb begin
        h       = '0;
        h.tid   = tid;
        h.ftype = ftype;
        h.ttype = ttype;
        h.prio  = HELLO_PRIO;
        h.crf   = 1'b0;
        h.size  = size;
        h.addr  = addr;
    end

    assign hdr = h;

endmodule

// File: rtl/rio_db_req.sv
// SRIO HELLO initiator: doorbell handshake, then NWRITE bursts of user data.
// Define DB_REQ_NWRITE_R_EN to send NWRITE_R and wait for each packet's response.
module rio_db_req
    import rio_pkg::*;
#(
    parameter logic [15:0] DB_INFO = 16'h0101,
    parameter int unsigned MAX_PLD = 256
) (
    input  logic        log_clk,
    input  logic        log_rst,
    input  logic [15:0] src_id,
    input  logic [15:0] des_id,
    input  logic        link_initialized,
    input  logic        dr_req_in,
    input  logic        nwr_req_in,
    output logic        rapidIO_ready_o,
    output logic        nwr_ready_o,
    output logic        nwr_busy_o,
    output logic        go,
    input  logic [33:0] user_addr,
    input  logic [3:0]  user_ftype,
    input  logic [3:0]  user_ttype,
    input  logic [11:0] user_tsize_in,
    input  logic [63:0] user_tdata_in,
    input  logic        user_tvalid_in,
    input  logic        user_tlast_in,
    input  logic [7:0]  user_tkeep_in,
    output logic        user_tready_o,
    output logic        ireq_tvalid_o,
    input  logic        ireq_tready_in,
    output logic        ireq_tlast_o,
    output logic [63:0] ireq_tdata_o,
    output logic [7:0]  ireq_tkeep_o,
    output logic [31:0] ireq_tuser_o,
    input  logic        iresp_tvalid_in,
    output logic        iresp_tready_o,
    input  logic        iresp_tlast_in,
    input  logic [63:0] iresp_tdata_in,
    input  logic [7:0]  iresp_tkeep_in,
    input  logic [31:0] iresp_tuser_in
);

`ifdef DB_REQ_NWRITE_R_EN
    localparam bit NWR_R_EN = 1'b1;
`else
    localparam bit NWR_R_EN = 1'b0;
`endif
    localparam logic [3:0]  NWR_TTYPE = NWR_R_EN ? TTYPE_NWRITE_R : TTYPE_NWRITE;
    localparam logic [12:0] MAX_PLD_B = 13'(MAX_PLD);

    rio_state_e  state_q, state_d;
    logic [7:0]  tid_q, tid_d;
    logic [33:0] addr_q, addr_d;
    logic [12:0] rem_q, rem_d;
    logic [5:0]  beats_q, beats_d;
    logic        resp_sop_q, resp_rdy_q;

    logic [12:0] pkt_bytes;
    logic [7:0]  pkt_size;
    logic [5:0]  pkt_beats;
    logic        data_last, resp_hit, resp_done;

    logic [7:0]  hb_tid, hb_size;
    logic [3:0]  hb_ftype, hb_ttype;
    logic [33:0] hb_addr;
    logic [63:0] hb_hdr;

    logic unused_inputs;
    assign unused_inputs = ^{user_ftype, user_ttype, user_tkeep_in, iresp_tkeep_in,
                             iresp_tuser_in, iresp_tdata_in[47:0]};

    assign pkt_bytes = (rem_q > MAX_PLD_B) ? MAX_PLD_B : rem_q;
    assign pkt_size  = 8'(pkt_bytes - 13'd1);
    assign pkt_beats = 6'((pkt_bytes + 13'd7) >> 3);
    assign data_last = (beats_q == 6'd1);

    // Only the first beat of a response carries a header; the status sits in the TTYPE slot.
    // tid_q has already advanced past the outstanding request.
    assign resp_hit  = iresp_tvalid_in && resp_rdy_q && resp_sop_q &&
                       (iresp_tdata_in[55:52] == FTYPE_RESPONSE) &&
                       (iresp_tdata_in[63:56] == tid_q - 8'd1);
    assign resp_done = (iresp_tdata_in[51:48] == RESP_DONE);

    assign iresp_tready_o = resp_rdy_q;

    always_comb begin
        hb_tid   = tid_q;
        hb_ftype = FTYPE_NWRITE;
        hb_ttype = NWR_TTYPE;
        hb_size  = pkt_size;
        hb_addr  = addr_q;
        if (state_q == StDbSend) begin
            hb_ftype = FTYPE_DOORBELL;
            hb_ttype = TTYPE_DOORBELL;
            hb_size  = 8'd0;
            hb_addr  = {2'b00, DB_INFO, 16'h0000};
        end
    end

    rio_hello_hdr u_hdr (
        .tid   (hb_tid),
        .ftype (hb_ftype),
        .ttype (hb_ttype),
        .size  (hb_size),
        .addr  (hb_addr),
        .hdr   (hb_hdr)
    );

    always_comb begin
        state_d         = state_q;
        tid_d           = tid_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        beats_d         = beats_q;
        rapidIO_ready_o = 1'b0;
        nwr_ready_o     = 1'b0;
        nwr_busy_o      = 1'b0;
        go              = 1'b0;
        user_tready_o   = 1'b0;
        ireq_tvalid_o   = 1'b0;
        ireq_tlast_o    = 1'b0;
        ireq_tdata_o    = '0;
        ireq_tkeep_o    = '0;
        ireq_tuser_o    = '0;

        if (!link_initialized) begin
            state_d = StLinkWait;
        end else begin
            unique case (state_q)
                StLinkWait: state_d = StDbIdle;
                StDbIdle: begin
                    rapidIO_ready_o = 1'b1;
                    if (dr_req_in) state_d = StDbSend;
                end
                StDbSend: begin
                    ireq_tvalid_o = 1'b1;
                    ireq_tlast_o  = 1'b1;
                    ireq_tdata_o  = hb_hdr;
                    ireq_tkeep_o  = 8'hFF;
                    ireq_tuser_o  = {src_id, des_id};
                    if (ireq_tready_in) begin
                        tid_d   = tid_q + 8'd1;
                        state_d = StDbWait;
                    end
                end
                StDbWait: begin
                    if (resp_hit) begin
                        if (resp_done) begin
                            go      = 1'b1;
                            state_d = StNwrIdle;
                        end else begin
                            state_d = StDbIdle;
                        end
                    end
                end
                StNwrIdle: begin
                    nwr_ready_o = 1'b1;
                    if (nwr_req_in) begin
                        addr_d  = user_addr;
                        rem_d   = {1'b0, user_tsize_in} + 13'd1;
                        state_d = StNwrHdr;
                    end
                end
                StNwrHdr: begin
                    nwr_busy_o    = 1'b1;
                    ireq_tvalid_o = 1'b1;
                    ireq_tdata_o  = hb_hdr;
                    ireq_tkeep_o  = 8'hFF;
                    ireq_tuser_o  = {src_id, des_id};
                    if (ireq_tready_in) begin
                        tid_d   = tid_q + 8'd1;
                        beats_d = pkt_beats;
                        state_d = StNwrData;
                    end
                end
                StNwrData: begin
                    nwr_busy_o    = 1'b1;
                    user_tready_o = ireq_tready_in;
                    ireq_tvalid_o = user_tvalid_in;
                    ireq_tlast_o  = data_last || user_tlast_in;
                    ireq_tdata_o  = user_tdata_in;
                    ireq_tkeep_o  = 8'hFF;
                    ireq_tuser_o  = {src_id, des_id};
                    if (user_tvalid_in && ireq_tready_in) begin
                        beats_d = beats_q - 6'd1;
                        if (data_last || user_tlast_in) begin
                            addr_d = addr_q + 34'(pkt_bytes);
                            // An early user tlast closes the whole session.
                            rem_d  = user_tlast_in ? 13'd0 : rem_q - pkt_bytes;
`ifdef DB_REQ_NWRITE_R_EN
                            state_d = StNwrResp;
`else
                            state_d = (rem_d == 13'd0) ? StNwrIdle : StNwrHdr;
`endif
                        end
                    end
                end
`ifdef DB_REQ_NWRITE_R_EN
                StNwrResp: begin
                    nwr_busy_o = 1'b1;
                    if (resp_hit) begin
                        state_d = (!resp_done || rem_q == 13'd0) ? StNwrIdle : StNwrHdr;
                    end
                end
`endif
                default: state_d = StLinkWait;
            endcase
        end
    end

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state_q    <= StLinkWait;
            tid_q      <= 8'd0;
            addr_q     <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            resp_sop_q <= 1'b1;
            resp_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beats_q    <= beats_d;
            resp_rdy_q <= 1'b1;
            if (iresp_tvalid_in && resp_rdy_q) resp_sop_q <= iresp_tlast_in;
        end
    end

endmodule

// File: tb/tb_rio_db_req.sv
// Directed bench for rio_db_req: doorbell handshake, NWRITE sessions, backpressure, link loss.
module tb_rio_db_req;

    logic        log_clk = 1'b0;
    logic        log_rst;
    logic [15:0] src_id, des_id;
    logic        link_initialized, dr_req_in, nwr_req_in;
    logic        rapidIO_ready_o, nwr_ready_o, nwr_busy_o, go;
    logic [33:0] user_addr;
    logic [3:0]  user_ftype, user_ttype;
    logic [11:0] user_tsize_in;
    logic [63:0] user_tdata_in;
    logic        user_tvalid_in, user_tlast_in;
    logic [7:0]  user_tkeep_in;
    logic        user_tready_o;
    logic        ireq_tvalid_o, ireq_tready_in, ireq_tlast_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic [31:0] ireq_tuser_o;
    logic        iresp_tvalid_in, iresp_tready_o, iresp_tlast_in;
    logic [63:0] iresp_tdata_in;
    logic [7:0]  iresp_tkeep_in;
    logic [31:0] iresp_tuser_in;

    rio_db_req dut (
        .log_clk          (log_clk),
        .log_rst          (log_rst),
        .src_id           (src_id),
        .des_id           (des_id),
        .link_initialized (link_initialized),
        .dr_req_in        (dr_req_in),
        .nwr_req_in       (nwr_req_in),
        .rapidIO_ready_o  (rapidIO_ready_o),
        .nwr_ready_o      (nwr_ready_o),
        .nwr_busy_o       (nwr_busy_o),
        .go               (go),
        .user_addr        (user_addr),
        .user_ftype       (user_ftype),
        .user_ttype       (user_ttype),
        .user_tsize_in    (user_tsize_in),
        .user_tdata_in    (user_tdata_in),
        .user_tvalid_in   (user_tvalid_in),
        .user_tlast_in    (user_tlast_in),
        .user_tkeep_in    (user_tkeep_in),
        .user_tready_o    (user_tready_o),
        .ireq_tvalid_o    (ireq_tvalid_o),
        .ireq_tready_in   (ireq_tready_in),
        .ireq_tlast_o     (ireq_tlast_o),
        .ireq_tdata_o     (ireq_tdata_o),
        .ireq_tkeep_o     (ireq_tkeep_o),
        .ireq_tuser_o     (ireq_tuser_o),
        .iresp_tvalid_in  (iresp_tvalid_in),
        .iresp_tready_o   (iresp_tready_o),
        .iresp_tlast_in   (iresp_tlast_in),
        .iresp_tdata_in   (iresp_tdata_in),
        .iresp_tkeep_in   (iresp_tkeep_in),
        .iresp_tuser_in   (iresp_tuser_in)
    );

    always #5 log_clk = ~log_clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [7:0]  keep;
        logic [31:0] user;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    localparam logic [31:0] IDS = 32'h0001_00F0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hello(input logic [7:0] tid, input logic [3:0] ft,
                                          input logic [3:0] tt, input logic [7:0] sz,
                                          input logic [33:0] a);
        return (64'(tid) << 56) | (64'(ft) << 52) | (64'(tt) << 48) | (64'd1 << 45) |
               (64'(sz) << 36) | 64'(a);
    endfunction

    function automatic logic [63:0] pat(input int i);
        return {16'hBEEF, 16'(i), 32'(i * 40503 + 1)};
    endfunction

    // Accepted request beats; inputs only change just after posedge, so negedge sees the fire.
    always @(negedge log_clk) begin
        if (ireq_tvalid_o && ireq_tready_in)
            got_q.push_back('{ireq_tdata_o, ireq_tlast_o, ireq_tkeep_o, ireq_tuser_o});
    end

    task automatic expect_session(input logic [33:0] a, input int unsigned len, input int early,
                                  input logic [7:0] tid_in, output logic [7:0] tid_out);
        int unsigned rem = len;
        logic [33:0] pa  = a;
        logic [7:0]  tid = tid_in;
        int          idx = 0;
        bit          stop = 0;
        while (!stop) begin
            int unsigned pb = (rem > 256) ? 256 : rem;
            int unsigned nb = (pb + 7) / 8;
            exp_q.push_back('{hello(tid, 4'd5, 4'd4, 8'(pb - 1), pa), 1'b0, 8'hFF, IDS});
            for (int i = 0; i < int'(nb) && !stop; i++) begin
                exp_q.push_back('{pat(idx), (i == int'(nb) - 1) || (idx == early), 8'hFF, IDS});
                if (idx == early) stop = 1;
                idx++;
            end
            tid = tid + 8'd1;
            pa  = pa + 34'(pb);
            rem = rem - pb;
            if (rem == 0) stop = 1;
        end
        tid_out = tid;
    endtask

    task automatic compare_beats(input string tag);
        check({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_ctl%0d", tag, i),
                  64'({got_q[i].last, got_q[i].keep, got_q[i].user}),
                  64'({exp_q[i].last, exp_q[i].keep, exp_q[i].user}));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge log_clk);
        #1;
    endtask

    task automatic doorbell();
        dr_req_in = 1'b1;
        tick();
        dr_req_in = 1'b0;
        tick();
    endtask

    task automatic send_resp(input logic [7:0] tid, input logic [3:0] status,
                             output logic go_seen);
        iresp_tdata_in  = (64'(tid) << 56) | (64'hD << 52) | (64'(status) << 48);
        iresp_tvalid_in = 1'b1;
        iresp_tlast_in  = 1'b1;
        @(negedge log_clk);
        go_seen = go;
        tick();
        iresp_tvalid_in = 1'b0;
        iresp_tlast_in  = 1'b0;
    endtask

    task automatic run_session(input string tag, input logic [33:0] a, input logic [11:0] ts,
                               input bit toggle, input int early);
        int idx = 0;
        int cyc = 0;
        bit fire;
        user_addr     = a;
        user_tsize_in = ts;
        nwr_req_in    = 1'b1;
        tick();
        nwr_req_in = 1'b0;
        check({tag, "_busy"}, 64'(nwr_busy_o), 64'd1);
        while (nwr_busy_o && cyc < 2000) begin
            ireq_tready_in = toggle ? cyc[0] : 1'b1;
            user_tvalid_in = 1'b1;
            user_tdata_in  = pat(idx);
            user_tlast_in  = (idx == early);
            @(negedge log_clk);
            fire = user_tready_o && user_tvalid_in;
            tick();
            if (fire) idx++;
            cyc++;
        end
        check({tag, "_done"}, 64'(cyc < 2000), 64'd1);
        user_tvalid_in = 1'b0;
        user_tlast_in  = 1'b0;
        ireq_tready_in = 1'b1;
        check({tag, "_nwr_ready"}, 64'({nwr_ready_o, nwr_busy_o}), 64'b10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic       g;
        logic [7:0] tid;

        log_rst = 1'b1;   link_initialized = 1'b0;
        src_id = 16'h0001; des_id = 16'h00F0;
        dr_req_in = 0; nwr_req_in = 0;
        user_addr = '0; user_ftype = 4'd5; user_ttype = 4'd4; user_tsize_in = '0;
        user_tdata_in = '0; user_tvalid_in = 0; user_tlast_in = 0; user_tkeep_in = 8'hFF;
        ireq_tready_in = 1'b1;
        iresp_tvalid_in = 0; iresp_tlast_in = 0; iresp_tdata_in = '0;
        iresp_tkeep_in = 8'hFF; iresp_tuser_in = 32'h00F0_0001;
        repeat (3) tick();

        check("rst_status", 64'({rapidIO_ready_o, nwr_ready_o, nwr_busy_o, go, user_tready_o}), 64'd0);
        check("rst_ireq", 64'({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o, ireq_tuser_o}), 64'd0);
        check("rst_iresp_rdy", 64'(iresp_tready_o), 64'd0);

        log_rst = 1'b0;
        tick();
        check("linkwait_ready", 64'(rapidIO_ready_o), 64'd0);
        check("iresp_rdy", 64'(iresp_tready_o), 64'd1);
        link_initialized = 1'b1;
        tick();
        check("db_idle_ready", 64'(rapidIO_ready_o), 64'd1);

        // Doorbell TID 0 refused with status 7, retried as TID 1.
        doorbell();
        exp_q.push_back('{64'h00A0_2000_0101_0000, 1'b1, 8'hFF, IDS});
        compare_beats("db0");
        check("db_wait_status", 64'({rapidIO_ready_o, nwr_ready_o}), 64'd0);
        send_resp(8'd0, 4'd7, g);
        check("db_err_go", 64'(g), 64'd0);
        check("db_err_retry", 64'({rapidIO_ready_o, nwr_ready_o}), 64'b10);

        doorbell();
        exp_q.push_back('{64'h01A0_2000_0101_0000, 1'b1, 8'hFF, IDS});
        compare_beats("db1");
        send_resp(8'd5, 4'd0, g);
        check("db_tid_mismatch_go", 64'(g), 64'd0);
        check("db_tid_mismatch_wait", 64'({rapidIO_ready_o, nwr_ready_o}), 64'd0);
        send_resp(8'd1, 4'd0, g);
        check("db_done_go", 64'(g), 64'd1);
        check("db_done_nwr_ready", 64'({nwr_ready_o, go, rapidIO_ready_o}), 64'b100);

        // 64 bytes at 0x1000: one packet, TID 2, 8 data beats.
        run_session("s64", 34'h1000, 12'd63, 1'b0, -1);
        expect_session(34'h1000, 64, -1, 8'd2, tid);
        compare_beats("s64");

        // 512 bytes with 50% backpressure: two 256-byte packets, TIDs 3/4.
        run_session("s512", 34'h1000, 12'd511, 1'b1, -1);
        expect_session(34'h1000, 512, -1, tid, tid);
        compare_beats("s512");

        // Early user tlast on the third beat closes the session.
        run_session("early", 34'h4000, 12'd63, 1'b0, 2);
        expect_session(34'h4000, 64, 2, tid, tid);
        compare_beats("early");

        // 11 bytes: size field 0x0A, two whole beats.
        run_session("s11", 34'h2000, 12'd10, 1'b1, -1);
        expect_session(34'h2000, 11, -1, tid, tid);
        compare_beats("s11");

        send_resp(tid - 8'd1, 4'd0, g);
        check("stray_resp_go", 64'(g), 64'd0);
        check("stray_resp_state", 64'({nwr_ready_o, rapidIO_ready_o}), 64'b10);

        // Link lost mid-burst.
        user_addr = 34'h3000; user_tsize_in = 12'd255; nwr_req_in = 1'b1;
        tick();
        nwr_req_in = 1'b0;
        user_tvalid_in = 1'b1;
        repeat (5) tick();
        check("mid_burst_busy", 64'(nwr_busy_o), 64'd1);
        link_initialized = 1'b0;
        tick();
        check("linkdown_status", 64'({rapidIO_ready_o, nwr_ready_o, nwr_busy_o, go, user_tready_o}), 64'd0);
        check("linkdown_ireq", 64'({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o}), 64'd0);
        check("linkdown_data", ireq_tdata_o, 64'd0);
        user_tvalid_in = 1'b0;
        got_q.delete();
        link_initialized = 1'b1;
        tick();
        check("relink_ready", 64'({rapidIO_ready_o, nwr_ready_o}), 64'b10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
